// File: rtl/cordic_func_scheduler.sv
// cordic_func_scheduler
//   Sequences the CORDIC function units. It accepts a function code and two
//   operands, then strobes the one unit that implements that function. It
//   waits for that unit's done, captures its 32-bit result and pulses done.
//   If the unit does not answer within TIMEOUT_CYCLES, or the function code
//   has no unit, the request still completes, with err=1 and result=0.
//
// Ports
//   clk, rst_n    rising-edge clock, synchronous active-low reset
//   start         request pulse, honoured only while busy=0
//   func          4-bit function code, sampled with start
//   op1, op2      signed 16-bit operands, sampled with start
//   unit_done     per-unit done strobe (bit i = unit i)
//   unit_result   packed unit results, unit i at [32i+31:32i]
//   unit_start    one-hot single-cycle start strobe to the selected unit
//   unit_func     registered function code for the units
//   unit_op1/2    registered operands for the units
//   busy          high from accept until completion
//   done          single-cycle completion pulse
//   err           timeout / invalid-function flag, held until next accept
//   result        captured result, held until next accept
module cordic_func_scheduler #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int NUM_UNITS      = 6
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic [3:0]                  func,
  input  logic signed [15:0]          op1,
  input  logic signed [15:0]          op2,
  input  logic [NUM_UNITS-1:0]        unit_done,
  input  logic [32*NUM_UNITS-1:0]     unit_result,
  output logic [NUM_UNITS-1:0]        unit_start,
  output logic [3:0]                  unit_func,
  output logic signed [15:0]          unit_op1,
  output logic signed [15:0]          unit_op2,
  output logic                        busy,
  output logic                        done,
  output logic                        err,
  output logic [31:0]                 result
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_FINISH,
    S_ERROR
  } state_t;

  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYCLES - 1);

  // Returns {valid, unit_index[2:0]} for a function code.
  function automatic logic [3:0] func_to_unit(input logic [3:0] f);
    case (f)
      4'd0, 4'd1: func_to_unit = 4'b1_000;
      4'd2, 4'd3: func_to_unit = 4'b1_001;
      4'd4, 4'd5: func_to_unit = 4'b1_010;
      4'd7:       func_to_unit = 4'b1_011;
      4'd6:       func_to_unit = 4'b1_100;
      4'd8:       func_to_unit = 4'b1_101;
      default:    func_to_unit = 4'b0_000;
    endcase
  endfunction

  state_t                state_q, state_d;
  logic [2:0]            sel_q, sel_d;
  logic [15:0]           cnt_q, cnt_d;
  logic [NUM_UNITS-1:0]  unit_start_q, unit_start_d;
  logic [3:0]            unit_func_q, unit_func_d;
  logic signed [15:0]    unit_op1_q, unit_op1_d;
  logic signed [15:0]    unit_op2_q, unit_op2_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic [31:0]           result_q, result_d;
  logic [3:0]            map;

  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    cnt_d        = cnt_q;
    unit_start_d = '0;
    unit_func_d  = unit_func_q;
    unit_op1_d   = unit_op1_q;
    unit_op2_d   = unit_op2_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    err_d        = err_q;
    result_d     = result_q;
    map          = func_to_unit(func);

    case (state_q)
      S_IDLE: begin
        if (start) begin
          unit_func_d = func;
          unit_op1_d  = op1;
          unit_op2_d  = op2;
          busy_d      = 1'b1;
          err_d       = 1'b0;
          result_d    = '0;
          sel_d       = map[2:0];
          if (map[3]) begin
            // The strobe is registered here so that it is high during ISSUE.
            unit_start_d[map[2:0]] = 1'b1;
            state_d = S_ISSUE;
          end else begin
            state_d = S_ERROR;
          end
        end
      end
      S_ISSUE: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // A done from the selected unit wins over a timeout in the same cycle.
        if (unit_done[sel_q]) begin
          result_d = unit_result[{sel_q, 5'b0} +: 32];
          err_d    = 1'b0;
          done_d   = 1'b1;
          busy_d   = 1'b0;
          state_d  = S_FINISH;
        end else if (cnt_q == CNT_LAST) begin
          result_d = '0;
          err_d    = 1'b1;
          done_d   = 1'b1;
          busy_d   = 1'b0;
          state_d  = S_FINISH;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_ERROR: begin
        result_d = '0;
        err_d    = 1'b1;
        done_d   = 1'b1;
        busy_d   = 1'b0;
        state_d  = S_FINISH;
      end
      S_FINISH: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      sel_q        <= '0;
      cnt_q        <= '0;
      unit_start_q <= '0;
      unit_func_q  <= '0;
      unit_op1_q   <= '0;
      unit_op2_q   <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      result_q     <= '0;
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      cnt_q        <= cnt_d;
      unit_start_q <= unit_start_d;
      unit_func_q  <= unit_func_d;
      unit_op1_q   <= unit_op1_d;
      unit_op2_q   <= unit_op2_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_q        <= err_d;
      result_q     <= result_d;
    end
  end

  assign unit_start = unit_start_q;
  assign unit_func  = unit_func_q;
  assign unit_op1   = unit_op1_q;
  assign unit_op2   = unit_op2_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;
  assign result     = result_q;

endmodule
